// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler that shares one byte-wide UART TX between two 32-bit telemetry sources.
// Each grant snapshots the winner's word and emits SYNC, ID, four data bytes and an XOR checksum.
module uart_frame_scheduler #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned GAP_CYC   = 16,
    parameter int unsigned GAP_W     = 8
) (
    input  logic        Clk,
    input  logic        rst_n,
    input  logic [1:0]  i_req,
    input  logic [31:0] i_data0,
    input  logic [31:0] i_data1,
    output logic [1:0]  o_ack,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [2:0]       LAST_IDX = 3'd6;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t           state;
    logic             rr_ptr;
    logic             winner;
    logic [31:0]      word;
    logic [7:0]       frame_id;
    logic [7:0]       frame_chk;
    logic [2:0]       byte_idx;
    logic [GAP_W-1:0] gap_cnt;

    logic             pick;
    logic [31:0]      grant_word;
    logic [7:0]       grant_id;
    logic [7:0]       grant_chk;

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] w,
                                              input logic [7:0]  id_b,
                                              input logic [7:0]  chk_b);
        case (idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = id_b;
            3'd2:    frame_byte = w[31:24];
            3'd3:    frame_byte = w[23:16];
            3'd4:    frame_byte = w[15:8];
            3'd5:    frame_byte = w[7:0];
            3'd6:    frame_byte = chk_b;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        pick = 1'b0;
        if (i_req == 2'b11) pick = rr_ptr;
        else                pick = i_req[1];
    end

    // The word is captured at the end of the ack cycle, so the source may change it right after.
    always_comb begin
        grant_word = winner ? i_data1 : i_data0;
        grant_id   = {7'd0, winner};
        grant_chk  = grant_id ^ grant_word[31:24] ^ grant_word[23:16]
                   ^ grant_word[15:8] ^ grant_word[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            winner     <= 1'b0;
            word       <= '0;
            frame_id   <= '0;
            frame_chk  <= '0;
            byte_idx   <= '0;
            gap_cnt    <= '0;
            o_ack      <= 2'b00;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        state  <= GRANT;
                        winner <= pick;
                        rr_ptr <= ~pick;
                        o_ack  <= pick ? 2'b10 : 2'b01;
                        o_busy <= 1'b1;
                    end
                end
                GRANT: begin
                    o_ack      <= 2'b00;
                    word       <= grant_word;
                    frame_id   <= grant_id;
                    frame_chk  <= grant_chk;
                    byte_idx   <= 3'd0;
                    o_tx_data  <= SYNC_BYTE;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    // Data and valid only move on an accepted handshake, never while ready is low.
                    if (o_tx_valid && i_tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= 8'h00;
                            if (GAP_CYC > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            byte_idx  <= byte_idx + 3'd1;
                            o_tx_data <= frame_byte(byte_idx + 3'd1, word, frame_id, frame_chk);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Interface invariants the downstream TX and the sources rely on.
    a_ack_onehot: assert property (@(posedge Clk) disable iff (!rst_n) $onehot0(o_ack));
    a_tx_hold: assert property (@(posedge Clk) disable iff (!rst_n)
        (o_tx_valid && !i_tx_ready) |=> (o_tx_valid && $stable(o_tx_data)));
    a_busy_state: assert property (@(posedge Clk) disable iff (!rst_n) o_busy == (state != IDLE));

endmodule
